// File: rtl/cube_sort_pkg.sv
// Shared constants and types for the cube sorter front end.
// Slot count, word width, pad value and the loader state set.
package cube_sort_pkg;

   localparam int CS_N_WORDS = 16;
   localparam int CS_WIDTH   = 16;
   localparam logic [CS_WIDTH-1:0] CS_PAD_VALUE = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } load_state_t;

   // Width able to hold the values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/cube_sort_loader.sv
// Serial-to-parallel block loader for the cube sorter.
// Packs up to N_WORDS words, pads the rest, holds the block stable.
module cube_sort_loader
   import cube_sort_pkg::*;
#(
   parameter int N_WORDS = CS_N_WORDS,
   parameter int WIDTH = CS_WIDTH,
   parameter int HOLD_CYCLES = 4,
   parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}}
) (
   input  logic clk,
   input  logic rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic in_valid,
   input  logic in_last,
   output logic in_ready,
   output logic [N_WORDS*WIDTH-1:0] out_data,
   output logic out_valid,
   output logic [cnt_w(N_WORDS)-1:0] out_count,
   output logic block_done
);

   localparam int IW = $clog2(N_WORDS);
   localparam int CW = cnt_w(N_WORDS);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(N_WORDS - 1);

   load_state_t state, state_n;
   logic [HW-1:0] hold, hold_n;
   logic [IW-1:0] idx;
   logic [WIDTH-1:0] slot [N_WORDS];
   logic accept;
   logic end_w;

   assign accept = (state == FILL) && in_valid;
   assign end_w = accept && (in_last || (idx == IDX_MAX));

   always_comb begin
      state_n = state;
      hold_n = hold;
      unique case (state)
         IDLE: state_n = FILL;
         FILL: begin
            if (end_w) begin
               state_n = HOLD;
               hold_n = HOLD_INIT;
            end
         end
         HOLD: begin
            if (hold == '0) state_n = FILL;
            else hold_n = hold - 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         hold <= '0;
      end else begin
         state <= state_n;
         hold <= hold_n;
      end
   end

   // Flags are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready <= 1'b0;
         out_valid <= 1'b0;
         block_done <= 1'b0;
      end else begin
         in_ready <= (state_n == FILL);
         out_valid <= (state_n == HOLD);
         block_done <= (state_n == HOLD) && (hold_n == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
         out_count <= '0;
         for (int j = 0; j < N_WORDS; j++) slot[j] <= '0;
      end else begin
         if (accept) begin
            slot[idx] <= in_data;
            if (end_w) begin
               for (int j = 0; j < N_WORDS; j++)
                  if (j > int'(idx)) slot[j] <= PAD_VALUE;
               out_count <= CW'(idx) + 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
         if ((state == HOLD) && (hold == '0)) idx <= '0;
      end
   end

   for (genvar i = 0; i < N_WORDS; i++) begin : g_out
      assign out_data[i*WIDTH +: WIDTH] = slot[i];
   end

endmodule

// File: tb/tb_cube_sort_loader.sv
// Directed bench for cube_sort_loader with a queue-based block model.
// Every cycle the flags and (when stable) the block are checked.
module tb_cube_sort_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] in_data = '0;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic in_ready;
   logic [255:0] out_data;
   logic out_valid;
   logic [4:0] out_count;
   logic block_done;

   int n_vec = 0;
   int n_bad = 0;

   cube_sort_loader dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_last(in_last),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_count(out_count),
      .block_done(block_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Model: 0 = idle, 1 = filling, 2 = presenting a block.
   int m_phase = 0;
   int m_left = 0;
   logic [15:0] m_words[$];
   logic [255:0] m_blk = '0;
   int m_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_left = 0;
         m_words.delete();
         m_blk = '0;
         m_cnt = 0;
      end else begin
         case (m_phase)
            0: m_phase = 1;
            1: if (in_valid) begin
               m_words.push_back(in_data);
               if (in_last || m_words.size() == 16) begin
                  for (int i = 0; i < 16; i++)
                     m_blk[i*16 +: 16] = (i < m_words.size()) ? m_words[i] : 16'hFFFF;
                  m_cnt = m_words.size();
                  m_words.delete();
                  m_left = 4;
                  m_phase = 2;
               end
            end
            default: begin
               m_left--;
               if (m_left == 0) m_phase = 1;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 256'(in_ready), 256'(m_phase == 1));
      chk("out_valid", 256'(out_valid), 256'(m_phase == 2));
      chk("block_done", 256'(block_done), 256'(m_phase == 2 && m_left == 1));
      if (m_phase != 1) begin
         chk("out_data", out_data, m_blk);
         chk("out_count", 256'(out_count), 256'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] w, input logic last);
      int b = 0;
      in_data = w;
      in_last = last;
      in_valid = 1'b1;
      while (!in_ready && b < 100) begin
         tick();
         b++;
      end
      if (b >= 100) begin
         n_vec++;
         n_bad++;
         $display("FAIL send_timeout: got in_ready=0 want 1");
      end
      tick();
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic wait_ready();
      int b = 0;
      while (!in_ready && b < 100) begin
         tick();
         b++;
      end
      chk("ready_return", 256'(in_ready), 256'(1));
   endtask

   function automatic logic [15:0] slot(input int i);
      return out_data[i*16 +: 16];
   endfunction

   logic [15:0] t1 [16] = '{3, 5, 8, 9, 10, 12, 14, 20,
                            95, 90, 60, 40, 35, 32, 18, 0};
   logic [15:0] t2 [5] = '{7, 1, 9, 2, 4};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcyc;
      int done_at;
      logic [255:0] held;
      #12;
      chk("rst_data", out_data, '0);
      chk("rst_ready", 256'(in_ready), 256'(0));
      tick();
      rst = 1'b0;
      tick();

      // 1: full gapless block
      for (int i = 0; i < 16; i++) send(t1[i], 1'b0);
      chk("t1_slot7", 256'(slot(7)), 256'(20));
      chk("t1_slot15", 256'(slot(15)), 256'(0));
      chk("t1_count", 256'(out_count), 256'(16));
      vcyc = 0;
      done_at = 0;
      while (out_valid && vcyc < 20) begin
         vcyc++;
         if (block_done) done_at = vcyc;
         tick();
      end
      chk("t1_hold_len", 256'(vcyc), 256'(4));
      chk("t1_done_at", 256'(done_at), 256'(4));
      chk("t1_ready_back", 256'(in_ready), 256'(1));

      // 2: short block
      for (int i = 0; i < 5; i++) send(t2[i], i == 4);
      chk("t2_slot4", 256'(slot(4)), 256'(4));
      chk("t2_slot5", 256'(slot(5)), 256'(16'hFFFF));
      chk("t2_count", 256'(out_count), 256'(5));
      wait_ready();

      // 3: single-word block
      send(16'd42, 1'b1);
      chk("t3_slot0", 256'(slot(0)), 256'(42));
      chk("t3_slot1", 256'(slot(1)), 256'(16'hFFFF));
      chk("t3_count", 256'(out_count), 256'(1));
      wait_ready();

      // 4: gapped block matches the gapless one
      for (int i = 0; i < 16; i++) begin
         send(t1[i], 1'b0);
         if (i < 15) begin
            chk("t4_no_early_valid", 256'(out_valid), 256'(0));
            tick();
         end
      end
      chk("t4_valid", 256'(out_valid), 256'(1));
      chk("t4_slot8", 256'(slot(8)), 256'(95));
      chk("t4_count", 256'(out_count), 256'(16));
      wait_ready();

      // 5: words offered during HOLD are ignored
      for (int i = 0; i < 5; i++) send(t2[i], i == 4);
      held = out_data;
      in_data = 16'd99;
      in_valid = 1'b1;
      vcyc = 0;
      while (!in_ready && vcyc < 100) begin
         chk("t5_held", out_data, held);
         tick();
         vcyc++;
      end
      send(16'd77, 1'b1);
      chk("t5_slot0", 256'(slot(0)), 256'(77));
      chk("t5_count", 256'(out_count), 256'(1));
      wait_ready();

      // 6: reset mid-fill
      for (int i = 0; i < 8; i++) send(t1[i], 1'b0);
      rst = 1'b1;
      #1;
      chk("t6_valid", 256'(out_valid), 256'(0));
      chk("t6_ready", 256'(in_ready), 256'(0));
      chk("t6_data", out_data, '0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6_ready_back", 256'(in_ready), 256'(1));
      send(16'd5, 1'b1);
      chk("t6_slot0", 256'(slot(0)), 256'(5));
      chk("t6_slot1", 256'(slot(1)), 256'(16'hFFFF));
      chk("t6_count", 256'(out_count), 256'(1));
      wait_ready();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
